shift_sequencer: RTL and testbench

- Multi-cycle shift unit that produces the shifter operand on the shifter side of the datapath's shift/ALU result select.
- Accepts an 8-bit operand, a shift amount and a mode on a Start pulse, then shifts one bit per clock.
- Presents Result and CarryOut with a one-cycle Done pulse.
- The control unit holds the Shift select high and captures Result on Done.

---
 rtl/shift_sequencer.sv | 98 +++++++++
 tb/tb_shift_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-free shifter: one bit position per clock, with a
// Busy/Done handshake toward the control unit that captures Result on Done.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Operand,
    input  logic [AMT_W-1:0] Amount,
    input  logic             Dir,
    input  logic             Arith,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic [1:0]       Dbg_state
);

    // Handshake: Start is a request that is accepted on any rising edge where
    // the unit is not in SHIFT (IDLE or DONE); it is silently dropped otherwise.
    // Done is a one-cycle strobe; Result/CarryOut stay stable from Done until
    // the next accepted Start, so the consumer may sample them on Done.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             carry_nxt;
    logic [AMT_W-1:0] count, count_nxt;
    logic             dir_q, dir_nxt;
    logic             arith_q, arith_nxt;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            Result   <= '0;
            CarryOut <= 1'b0;
            count    <= '0;
            dir_q    <= 1'b0;
            arith_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            Result   <= result_nxt;
            CarryOut <= carry_nxt;
            count    <= count_nxt;
            dir_q    <= dir_nxt;
            arith_q  <= arith_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        result_nxt = Result;
        carry_nxt  = CarryOut;
        count_nxt  = count;
        dir_nxt    = dir_q;
        arith_nxt  = arith_q;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    result_nxt = Operand;
                    carry_nxt  = 1'b0;
                    count_nxt  = Amount;
                    dir_nxt    = Dir;
                    arith_nxt  = Arith;
                    state_nxt  = (Amount == '0) ? DONE : SHIFT;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (!dir_q) begin
                    carry_nxt  = Result[WIDTH-1];
                    result_nxt = {Result[WIDTH-2:0], 1'b0};
                end else begin
                    // Sign fill only applies to right shifts.
                    carry_nxt  = Result[0];
                    result_nxt = {arith_q & Result[WIDTH-1], Result[WIDTH-1:1]};
                end
                count_nxt = count - 1'b1;
                if (count == AMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy      = (state == SHIFT);
    assign Done      = (state == DONE);
    assign Dbg_state = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed operations push expected
// {Result,CarryOut}; a monitor pops and compares on every Done strobe.
module tb_shift_sequencer;

    logic       CLK;
    logic       Reset_n;
    logic       Start;
    logic [7:0] Operand;
    logic [2:0] Amount;
    logic       Dir;
    logic       Arith;
    logic       Busy;
    logic       Done;
    logic [7:0] Result;
    logic       CarryOut;
    logic [1:0] Dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [8:0] exp_q[$];

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .CLK(CLK),
        .Reset_n(Reset_n),
        .Start(Start),
        .Operand(Operand),
        .Amount(Amount),
        .Dir(Dir),
        .Arith(Arith),
        .Busy(Busy),
        .Done(Done),
        .Result(Result),
        .CarryOut(CarryOut),
        .Dbg_state(Dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge CLK) begin
        if (Reset_n === 1'b1 && Done === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_done: result=0x%02h carry=%0b with nothing expected",
                         Result, CarryOut);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({Result, CarryOut} !== e) begin
                    tests_failed++;
                    $display("FAIL done_result: got result=0x%02h carry=%0b expected result=0x%02h carry=%0b",
                             Result, CarryOut, e[8:1], e[0]);
                end
            end
        end
    end

    // driver: called just after a falling edge; returns 1 time unit after the accepting edge
    task automatic issue(input logic [7:0] op, input logic [2:0] amt, input logic dir,
                         input logic arith, input logic [7:0] er, input logic ec,
                         input bit expect_done);
        Operand = op;
        Amount  = amt;
        Dir     = dir;
        Arith   = arith;
        Start   = 1'b1;
        if (expect_done) exp_q.push_back({er, ec});
        @(posedge CLK);
        #1;
        Start   = 1'b0;
        Operand = 8'($urandom_range(0, 255));
        Amount  = 3'($urandom_range(0, 7));
        Dir     = 1'($urandom_range(0, 1));
        Arith   = 1'($urandom_range(0, 1));
    endtask

    // Measures the cycle (counted from the one after the accepting edge) where
    // Done shows up, and how many cycles Busy was high before it.
    task automatic wait_done(input logic [2:0] amt, input bit poke);
        int k;
        int busy_cycles;
        bit seen;
        busy_cycles = 0;
        seen = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (Busy === 1'b1) busy_cycles++;
            if (poke && k == 2) begin
                Start   = 1'b1;
                Operand = 8'hFF;
                Amount  = 3'd1;
                Dir     = 1'b1;
            end
            if (poke && k == 3) Start = 1'b0;
            if (Done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL done_timeout: no Done within 20 cycles for amount %0d", amt);
        end else begin
            check("done_latency", 32'(k), 32'(amt) + 32'd1);
            check("busy_cycles", 32'(busy_cycles), 32'(amt));
        end
    endtask

    task automatic run_op(input logic [7:0] op, input logic [2:0] amt, input logic dir,
                          input logic arith, input logic [7:0] er, input logic ec,
                          input bit poke);
        @(negedge CLK);
        issue(op, amt, dir, arith, er, ec, 1'b1);
        wait_done(amt, poke);
    endtask

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        Operand = '0;
        Amount  = '0;
        Dir     = 1'b0;
        Arith   = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_result", 32'(Result), 32'h00);
        check("reset_carry", 32'(CarryOut), 32'd0);
        check("reset_state", 32'(Dbg_state), 32'd0);
        Reset_n = 1'b1;

        // op, amount, dir, arith, expected result, expected carry, poke
        run_op(8'h81, 3'd1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0);
        run_op(8'h0F, 3'd2, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0);
        run_op(8'h80, 3'd3, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op(8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
        run_op(8'h01, 3'd4, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1);
        run_op(8'hFF, 3'd7, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0);
        run_op(8'hB5, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        run_op(8'hB5, 3'd3, 1'b0, 1'b0, 8'hA8, 1'b1, 1'b0);
        run_op(8'hB5, 3'd1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
        run_op(8'hC3, 3'd2, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b0);

        // back-to-back: new Start during the DONE cycle, no IDLE gap
        @(negedge CLK);
        issue(8'h3C, 3'd2, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b1);
        wait_done(3'd2, 1'b0);
        issue(8'h80, 3'd7, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
        check("b2b_busy_now", 32'(Busy), 32'd1);
        wait_done(3'd7, 1'b0);

        // asynchronous reset in the middle of a shift
        @(negedge CLK);
        issue(8'hFF, 3'd5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        Reset_n = 1'b0;
        #1;
        check("midreset_busy", 32'(Busy), 32'd0);
        check("midreset_done", 32'(Done), 32'd0);
        check("midreset_result", 32'(Result), 32'h00);
        check("midreset_carry", 32'(CarryOut), 32'd0);
        @(negedge CLK);
        Reset_n = 1'b1;
        repeat (10) @(negedge CLK);
        check("post_reset_idle", 32'(Dbg_state), 32'd0);

        run_op(8'h81, 3'd1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0);
        repeat (3) @(negedge CLK);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
